cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_pkg.sv | 85 ++++++++
 rtl/cpu_controller.sv | 114 +++++++++++
 tb/tb_cpu_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared controller definitions: FSM states, instruction field encodings, mux selects.
// Latency: none (types, constants and a pure decode function only).
// Backpressure: not applicable.
package cpu_pkg;

    // Controller states
    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // Instruction class latched in DECODE so EXEC needs no further IR decode
    typedef enum logic [1:0] {
        K_MOV_REG = 2'd0,
        K_CMP     = 2'd1,
        K_ALU     = 2'd2
    } kind_t;

    // opcode field, IR[15:13]
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    // ALU_op field, IR[12:11]
    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_CMP     = 2'b01;
    localparam logic [1:0] ALU_AND     = 2'b10;
    localparam logic [1:0] ALU_MVN     = 2'b11;
    localparam logic [1:0] ALU_MOV_REG = 2'b00;
    localparam logic [1:0] ALU_MOV_IMM = 2'b10;

    // Register-field select to the decoder
    localparam logic [1:0] RS_RM = 2'b00;
    localparam logic [1:0] RS_RD = 2'b01;
    localparam logic [1:0] RS_RN = 2'b10;

    // Write-back source select
    localparam logic [1:0] WB_C   = 2'b00;
    localparam logic [1:0] WB_IMM = 2'b10;

    // Registered control outputs of the controller
    typedef struct packed {
        logic       waiting;
        logic       halted;
        logic       w_en;
        logic       en_A;
        logic       en_B;
        logic       en_C;
        logic       en_status;
        logic       sel_A;
        logic [1:0] reg_sel;
        logic [1:0] wb_sel;
    } ctrl_t;

    // Moore output decode: a function of the state (and its latched class) only
    function automatic ctrl_t ctrl_decode(input state_t s, input kind_t k);
        ctrl_t c;
        c = '0;
        case (s)
            S_WAIT:   c.waiting = 1'b1;
            S_GET_A:  begin c.en_A = 1'b1; c.reg_sel = RS_RN; end
            S_GET_B:  begin c.en_B = 1'b1; c.reg_sel = RS_RM; end
            S_EXEC: begin
                if (k == K_CMP) begin
                    c.en_status = 1'b1;
                end else begin
                    c.en_C  = 1'b1;
                    c.sel_A = (k == K_MOV_REG);
                end
            end
            S_WR_REG: begin c.w_en = 1'b1; c.reg_sel = RS_RD; c.wb_sel = WB_C; end
            S_WR_IMM: begin c.w_en = 1'b1; c.reg_sel = RS_RN; c.wb_sel = WB_IMM; end
            S_HALT:   c.halted = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Multicycle CPU control FSM with retired-instruction counter.
// Latency: outputs registered and aligned with the state; 1 cycle per state.
// Backpressure: none; start is only looked at in WAIT, HALT holds until reset.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [1:0]       ALU_op,
    output logic             waiting,
    output logic             halted,
    output logic             illegal,
    output logic [1:0]       reg_sel,
    output logic [1:0]       wb_sel,
    output logic             w_en,
    output logic             en_A,
    output logic             en_B,
    output logic             en_C,
    output logic             en_status,
    output logic             sel_A,
    output logic [CNT_W-1:0] instr_count
);

    localparam ctrl_t CTRL_RESET = ctrl_decode(S_WAIT, K_ALU);

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             bad_enc;

    // Next-state, instruction-class capture and retire detection
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        retire  = 1'b0;
        bad_enc = 1'b0;
        case (state_q)
            S_WAIT: if (start) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_MOV && ALU_op == ALU_MOV_IMM) begin
                    state_d = S_WR_IMM;
                end else if (opcode == OP_MOV && ALU_op == ALU_MOV_REG) begin
                    state_d = S_GET_B;
                    kind_d  = K_MOV_REG;
                end else if (opcode == OP_ALU) begin
                    state_d = S_GET_A;
                    case (ALU_op)
                        ALU_CMP:                   kind_d = K_CMP;
                        ALU_ADD, ALU_AND, ALU_MVN: kind_d = K_ALU;
                        default:                   kind_d = K_ALU;
                    endcase
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    bad_enc = 1'b1;
                end
            end
            S_GET_A: state_d = S_GET_B;
            S_GET_B: state_d = S_EXEC;
            S_EXEC: begin
                if (kind_q == K_CMP) begin
                    state_d = S_WAIT;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WR_REG;
                end
            end
            S_WR_REG, S_WR_IMM: begin
                state_d = S_WAIT;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_WAIT;
        endcase
    end

    // State, registered outputs for the next state, and the wrapping retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            kind_q  <= K_ALU;
            ctrl_q  <= CTRL_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            ctrl_q  <= ctrl_decode(state_d, kind_d);
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The unsupported encoding is only visible while DECODE looks at the IR
    assign illegal     = bad_enc;
    assign waiting     = ctrl_q.waiting;
    assign halted      = ctrl_q.halted;
    assign w_en        = ctrl_q.w_en;
    assign en_A        = ctrl_q.en_A;
    assign en_B        = ctrl_q.en_B;
    assign en_C        = ctrl_q.en_C;
    assign en_status   = ctrl_q.en_status;
    assign sel_A       = ctrl_q.sel_A;
    assign reg_sel     = ctrl_q.reg_sel;
    assign wb_sel      = ctrl_q.wb_sel;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-cycle output vectors and retire count.
// Latency: each step samples 1 time unit after the rising edge.
// Backpressure: not applicable; all waits are fixed cycle counts.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] opcode;
    logic [1:0] alu_op;
    logic       waiting, halted, illegal, w_en, en_A, en_B, en_C, en_status, sel_A;
    logic [1:0] reg_sel, wb_sel;
    logic [3:0] instr_count;

    int checks = 0;
    int errors = 0;

    // {waiting,halted,illegal,w_en,en_A,en_B,en_C,en_status,sel_A,reg_sel,wb_sel}
    localparam logic [12:0] V_WAIT   = 13'b1_0_0_0_0_0_0_0_0_00_00;
    localparam logic [12:0] V_DEC    = 13'b0_0_0_0_0_0_0_0_0_00_00;
    localparam logic [12:0] V_ILL    = 13'b0_0_1_0_0_0_0_0_0_00_00;
    localparam logic [12:0] V_GETA   = 13'b0_0_0_0_1_0_0_0_0_10_00;
    localparam logic [12:0] V_GETB   = 13'b0_0_0_0_0_1_0_0_0_00_00;
    localparam logic [12:0] V_EXALU  = 13'b0_0_0_0_0_0_1_0_0_00_00;
    localparam logic [12:0] V_EXMOV  = 13'b0_0_0_0_0_0_1_0_1_00_00;
    localparam logic [12:0] V_EXCMP  = 13'b0_0_0_0_0_0_0_1_0_00_00;
    localparam logic [12:0] V_WRREG  = 13'b0_0_0_1_0_0_0_0_0_01_00;
    localparam logic [12:0] V_WRIMM  = 13'b0_0_0_1_0_0_0_0_0_10_10;
    localparam logic [12:0] V_HALT   = 13'b0_1_0_0_0_0_0_0_0_00_00;

    cpu_controller #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .opcode      (opcode),
        .ALU_op      (alu_op),
        .waiting     (waiting),
        .halted      (halted),
        .illegal     (illegal),
        .reg_sel     (reg_sel),
        .wb_sel      (wb_sel),
        .w_en        (w_en),
        .en_A        (en_A),
        .en_B        (en_B),
        .en_C        (en_C),
        .en_status   (en_status),
        .sel_A       (sel_A),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {waiting, halted, illegal, w_en, en_A, en_B, en_C, en_status, sel_A, reg_sel, wb_sel};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] exp);
        checks++;
        assert (instr_count === exp) else begin
            errors++;
            $error("FAIL %s: instr_count observed=%0d expected=%0d", tag, instr_count, exp);
        end
    endtask

    // Present an instruction with start for one edge; returns in DECODE
    task automatic issue(input logic [2:0] op, input logic [1:0] alu);
        opcode = op;
        alu_op = alu;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        opcode = 3'b000;
        alu_op = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check_ctrl("reset_outputs", V_WAIT);
        check_cnt("reset_count", 4'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_ctrl("idle_wait", V_WAIT);

        // MOV Rn,#imm8
        issue(3'b110, 2'b10);
        check_ctrl("movi_decode", V_DEC);
        tick(); check_ctrl("movi_wr_imm", V_WRIMM);
        tick(); check_ctrl("movi_wait", V_WAIT);
        check_cnt("movi_count", 4'd1);

        // ADD; start pulses outside WAIT must be ignored
        issue(3'b101, 2'b00);
        check_ctrl("add_decode", V_DEC);
        start = 1'b1;
        tick(); check_ctrl("add_get_a", V_GETA);
        tick(); check_ctrl("add_get_b", V_GETB);
        start = 1'b0;
        tick(); check_ctrl("add_exec", V_EXALU);
        tick(); check_ctrl("add_wr_reg", V_WRREG);
        tick(); check_ctrl("add_wait", V_WAIT);
        check_cnt("add_count", 4'd2);

        // CMP: status update, no write-back
        issue(3'b101, 2'b01);
        check_ctrl("cmp_decode", V_DEC);
        tick(); check_ctrl("cmp_get_a", V_GETA);
        tick(); check_ctrl("cmp_get_b", V_GETB);
        tick(); check_ctrl("cmp_exec", V_EXCMP);
        tick(); check_ctrl("cmp_wait", V_WAIT);
        check_cnt("cmp_count", 4'd3);

        // MOV Rd,Rm skips GET_A and zeroes operand A
        issue(3'b110, 2'b00);
        check_ctrl("movr_decode", V_DEC);
        tick(); check_ctrl("movr_get_b", V_GETB);
        tick(); check_ctrl("movr_exec", V_EXMOV);
        tick(); check_ctrl("movr_wr_reg", V_WRREG);
        tick(); check_ctrl("movr_wait", V_WAIT);
        check_cnt("movr_count", 4'd4);

        // MVN follows the generic ALU path
        issue(3'b101, 2'b11);
        tick(); check_ctrl("mvn_get_a", V_GETA);
        tick(); tick(); check_ctrl("mvn_exec", V_EXALU);
        tick(); check_ctrl("mvn_wr_reg", V_WRREG);
        tick(); check_ctrl("mvn_wait", V_WAIT);
        check_cnt("mvn_count", 4'd5);

        // Unsupported encodings: one-cycle illegal, not counted
        issue(3'b000, 2'b00);
        check_ctrl("ill000_decode", V_ILL);
        tick(); check_ctrl("ill000_wait", V_WAIT);
        check_cnt("ill000_count", 4'd5);
        issue(3'b110, 2'b01);
        check_ctrl("ill110_decode", V_ILL);
        tick(); check_ctrl("ill110_wait", V_WAIT);
        check_cnt("ill110_count", 4'd5);

        // start held high re-launches on each return to WAIT
        opcode = 3'b110; alu_op = 2'b10; start = 1'b1;
        tick(); check_ctrl("hold_decode1", V_DEC);
        tick(); check_ctrl("hold_wr_imm1", V_WRIMM);
        tick(); check_ctrl("hold_wait1", V_WAIT);
        tick(); check_ctrl("hold_decode2", V_DEC);
        start = 1'b0;
        tick(); check_ctrl("hold_wr_imm2", V_WRIMM);
        tick(); check_ctrl("hold_wait2", V_WAIT);
        check_cnt("hold_count", 4'd7);

        // Reset during GET_B of ADD aborts with no write
        issue(3'b101, 2'b00);
        tick(); tick(); check_ctrl("abort_get_b", V_GETB);
        rst_n = 1'b0;
        #1;
        check_ctrl("abort_immediate", V_WAIT);
        check_cnt("abort_count", 4'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); check_ctrl("abort_after", V_WAIT);
        end

        // Fill the 4-bit counter to 15, then wrap on one more MOV
        for (int i = 0; i < 15; i++) begin
            issue(3'b110, 2'b10);
            tick(); tick();
        end
        check_cnt("count_max", 4'd15);
        issue(3'b110, 2'b10);
        tick(); tick();
        check_ctrl("wrap_wait", V_WAIT);
        check_cnt("count_wrap", 4'd0);

        // HALT counts once and ignores start until reset
        issue(3'b111, 2'b00);
        check_ctrl("halt_decode", V_DEC);
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            tick(); check_ctrl("halt_hold", V_HALT);
        end
        start = 1'b0;
        check_cnt("halt_count", 4'd1);
        rst_n = 1'b0;
        #1;
        check_ctrl("halt_reset", V_WAIT);
        check_cnt("halt_reset_count", 4'd0);
        tick();
        rst_n = 1'b1;
        tick(); check_ctrl("post_halt_wait", V_WAIT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
